// File: rtl/int_ctrl18_pkg.sv
// Shared constants and types for the Core18 interrupt controller.
package int_ctrl18_pkg;
  localparam int DATA_W     = 18;
  localparam int NUM_LEVELS = 15;

  localparam logic [1:0] OFS_ENABLE  = 2'd0;
  localparam logic [1:0] OFS_PENDING = 2'd1;
  localparam logic [1:0] OFS_EDGE    = 2'd2;
  localparam logic [1:0] OFS_SOFT    = 2'd3;

  typedef logic [3:0]            vector_t;
  typedef logic [NUM_LEVELS:1]   level_t;

  // Places a level vector on the port bus; bits 17:16 and 0 are always zero.
  function automatic logic [DATA_W-1:0] to_word(input level_t v);
    return {2'b00, v, 1'b0};
  endfunction
endpackage

// File: rtl/int_ctrl18_irq_sync.sv
// Multi-flop synchronizer for asynchronous request lines with rising-edge detect.
module irq_sync #(
  parameter int WIDTH       = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] irq,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);
  logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) chain[s] <= '0;
      prev <= '0;
    end else begin
      chain[0] <= irq;
      for (int s = 1; s < SYNC_STAGES; s++) chain[s] <= chain[s-1];
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
endmodule

// File: rtl/int_ctrl18.sv
// Core18 interrupt controller: latches 15 prioritized requests and presents the
// highest pending enabled level on VECTOR; programmed over the core port bus.
module int_ctrl18
  import int_ctrl18_pkg::*;
#(
  parameter logic [17:0] BASE_ADRS   = 18'o000100,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [14:0] IRQ,
  input  logic        PORT_WR,
  input  logic        PORT_RD,
  input  logic [17:0] ADRS,
  input  logic [17:0] WDATA,
  output logic [17:0] RDATA,
  output logic [3:0]  VECTOR
);
  logic [DATA_W-1:0] ofs;
  logic              in_range;
  logic              wr_en;
  level_t            enable, edge_mode, latch, pending_p0;
  level_t            sync, rise, clr, softset, latch_d, pending_d, req;
  vector_t           vec_d, vector_p1;
  logic              unused_wdata;

  assign ofs          = ADRS - BASE_ADRS;
  assign in_range     = ~|ofs[DATA_W-1:2];
  assign wr_en        = PORT_WR & in_range;
  assign unused_wdata = ^{WDATA[17:16], WDATA[0]};

  irq_sync #(
    .WIDTH       (NUM_LEVELS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (CLK),
    .rst  (RESET),
    .irq  (IRQ),
    .sync (sync),
    .rise (rise)
  );

  assign clr     = (wr_en && ofs[1:0] == OFS_PENDING) ? WDATA[15:1] : '0;
  assign softset = (wr_en && ofs[1:0] == OFS_SOFT)    ? WDATA[15:1] : '0;

  // Set terms are ORed after the clear so a same-cycle rise or soft set survives W1C.
  // Level-mode bits keep only soft requests in the latch; the live line is ORed in.
  assign latch_d   = (latch & ~clr) | (rise & edge_mode) | softset;
  assign pending_d = latch_d | (sync & ~edge_mode);
  assign req       = pending_p0 & enable;

  always_comb begin
    vec_d = '0;
    for (int i = 1; i <= NUM_LEVELS; i++)
      if (req[i]) vec_d = vector_t'(i);
  end

  // Stage p0: register file, latches and PENDING; stage p1: encoded VECTOR.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      enable     <= '0;
      edge_mode  <= '0;
      latch      <= '0;
      pending_p0 <= '0;
      vector_p1  <= '0;
    end else begin
      if (wr_en && ofs[1:0] == OFS_ENABLE) enable    <= WDATA[15:1];
      if (wr_en && ofs[1:0] == OFS_EDGE)   edge_mode <= WDATA[15:1];
      latch      <= latch_d;
      pending_p0 <= pending_d;
      vector_p1  <= vec_d;
    end
  end

  assign VECTOR = vector_p1;

  always_comb begin
    RDATA = '0;
    if (PORT_RD && in_range) begin
      case (ofs[1:0])
        OFS_ENABLE:  RDATA = to_word(enable);
        OFS_PENDING: RDATA = to_word(pending_p0);
        OFS_EDGE:    RDATA = to_word(edge_mode);
        default:     RDATA = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_int_ctrl18.sv
// Scoreboard bench for int_ctrl18: directed port-bus and IRQ sequences.
module tb_int_ctrl18;
  localparam logic [17:0] BASE = 18'o000100;
  localparam logic [17:0] A_EN = BASE;
  localparam logic [17:0] A_PD = BASE + 18'd1;
  localparam logic [17:0] A_ED = BASE + 18'd2;
  localparam logic [17:0] A_SF = BASE + 18'd3;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [14:0] IRQ = '0;
  logic        PORT_WR = 1'b0;
  logic        PORT_RD = 1'b0;
  logic [17:0] ADRS = '0;
  logic [17:0] WDATA = '0;
  logic [17:0] RDATA;
  logic [3:0]  VECTOR;

  typedef struct {
    string       name;
    logic [17:0] rdata;
    logic [3:0]  vec;
  } exp_t;

  exp_t exp_q[$];
  logic look_stb = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int_ctrl18 #(.BASE_ADRS(BASE), .SYNC_STAGES(2)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .IRQ    (IRQ),
    .PORT_WR(PORT_WR),
    .PORT_RD(PORT_RD),
    .ADRS   (ADRS),
    .WDATA  (WDATA),
    .RDATA  (RDATA),
    .VECTOR (VECTOR)
  );

  always #5 CLK = ~CLK;

  // Monitor: every strobed cycle pops one expectation and checks RDATA and VECTOR.
  always @(negedge CLK) begin
    if (look_stb) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_underflow got empty queue want entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (RDATA !== e.rdata) begin
          n_bad++;
          $display("FAIL %s rdata got %o want %o", e.name, RDATA, e.rdata);
        end
        n_cmp++;
        if (VECTOR !== e.vec) begin
          n_bad++;
          $display("FAIL %s vector got %0d want %0d", e.name, VECTOR, e.vec);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic wr(input logic [17:0] a, input logic [17:0] d);
    ADRS = a; WDATA = d; PORT_WR = 1'b1;
    step();
    PORT_WR = 1'b0;
  endtask

  // Observes state after the most recent edge; rd=0 also checks RDATA gating.
  task automatic look(input string name, input logic [17:0] a, input logic rd,
                      input logic [17:0] exp_r, input logic [3:0] exp_v);
    exp_t e;
    e.name = name; e.rdata = exp_r; e.vec = exp_v;
    exp_q.push_back(e);
    ADRS = a; PORT_RD = rd; look_stb = 1'b1;
    step();
    look_stb = 1'b0; PORT_RD = 1'b0;
  endtask

  initial begin
    // 1: reset state
    repeat (3) step();
    RESET = 1'b0;
    look("rst_enable",  A_EN, 1'b1, 18'o0, 4'd0);
    look("rst_pending", A_PD, 1'b1, 18'o0, 4'd0);
    look("rst_edge",    A_ED, 1'b1, 18'o0, 4'd0);
    look("rst_soft",    A_SF, 1'b1, 18'o0, 4'd0);

    // 2: edge mode, level 7, one-clock pulse
    wr(A_EN, 18'o000200);
    wr(A_ED, 18'o000200);
    look("en7_readback", A_EN, 1'b1, 18'o000200, 4'd0);
    IRQ = 15'h0040;
    step();
    IRQ = '0;
    look("p7_edgeN",   A_PD, 1'b1, 18'o0,      4'd0);
    look("p7_edgeN1",  A_PD, 1'b1, 18'o0,      4'd0);
    look("p7_edgeN2",  A_PD, 1'b1, 18'o000200, 4'd0);
    look("v7_edgeN3",  A_EN, 1'b0, 18'o0,      4'd7);
    repeat (3) step();
    look("v7_hold",    A_PD, 1'b1, 18'o000200, 4'd7);
    wr(A_PD, 18'o000200);
    look("p7_cleared", A_PD, 1'b1, 18'o0,      4'd7);
    look("v7_dropped", A_EN, 1'b0, 18'o0,      4'd0);

    // 3: level mode, levels 5 and 12 held high
    wr(A_ED, 18'o0);
    wr(A_EN, 18'o177776);
    IRQ = 15'h0810;
    repeat (4) step();
    look("v12_level",   A_PD, 1'b1, 18'o010040, 4'd12);
    IRQ = 15'h0010;
    step();
    step();
    step();
    look("v12_lag",     A_EN, 1'b0, 18'o0,      4'd12);
    look("v5_after",    A_PD, 1'b1, 18'o000040, 4'd5);
    wr(A_PD, 18'o000040);
    step();
    look("w1c_level_hi", A_PD, 1'b1, 18'o000040, 4'd5);
    IRQ = '0;
    repeat (4) step();
    look("level_idle",  A_PD, 1'b1, 18'o0,      4'd0);

    // 4: soft request on masked level 15, then unmask
    wr(A_EN, 18'o077776);
    wr(A_SF, 18'o100000);
    look("soft_pending", A_PD, 1'b1, 18'o100000, 4'd0);
    look("soft_reads0",  A_SF, 1'b1, 18'o0,      4'd0);
    look("oor_above",    BASE + 18'd4, 1'b1, 18'o0, 4'd0);
    look("oor_below",    BASE - 18'd1, 1'b1, 18'o0, 4'd0);
    wr(A_EN, 18'o177776);
    look("v15_lag",      A_EN, 1'b1, 18'o177776, 4'd0);
    look("v15_unmask",   A_EN, 1'b0, 18'o0,      4'd15);
    wr(A_PD, 18'o100000);
    step();
    look("soft_clear",   A_PD, 1'b1, 18'o0,      4'd0);

    // 5: edge mode level 3, rise and W1C on the same edge
    wr(A_ED, 18'o000010);
    IRQ = 15'h0004;
    step();
    step();
    wr(A_PD, 18'o000010);
    look("set_wins",     A_PD, 1'b1, 18'o000010, 4'd0);
    look("v3",           A_EN, 1'b0, 18'o0,      4'd3);
    wr(A_PD, 18'o000010);
    look("edge_w1c_hi",  A_PD, 1'b1, 18'o0,      4'd3);
    look("v3_dropped",   A_EN, 1'b0, 18'o0,      4'd0);
    IRQ = '0;
    repeat (3) step();

    // 6: reset in the middle of a write with level 9 pending
    wr(A_SF, 18'o001000);
    step();
    look("v9",           A_PD, 1'b1, 18'o001000, 4'd9);
    RESET = 1'b1; ADRS = A_EN; WDATA = 18'o177776; PORT_WR = 1'b1;
    step();
    RESET = 1'b0; PORT_WR = 1'b0;
    look("rst2_enable",  A_EN, 1'b1, 18'o0, 4'd0);
    look("rst2_pending", A_PD, 1'b1, 18'o0, 4'd0);
    look("rst2_edge",    A_ED, 1'b1, 18'o0, 4'd0);

    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/int_ctrl18.md
Name: int_ctrl18

Overview:
- Interrupt controller for the Core18 processor. It drives the core's 4-bit VECTOR input.
- Collects 15 peripheral request lines, IRQ[15:1], one per priority level.
- Latches requests (edge or level per line) and masks them with an enable register.
- Presents the highest pending enabled level on VECTOR. The core accepts a vector numerically greater than its current level, so 15 is the highest priority and 0 means no request.
- Software programs and acknowledges the controller through the core's port bus.

Parameters:
- BASE_ADRS, 18'o000100: port address of register 0; the block decodes BASE_ADRS..BASE_ADRS+3.
- SYNC_STAGES, 2: synchronizer depth on IRQ inputs; minimum 2.

Ports:
- CLK  in  1: system clock, rising edge.
- RESET  in  1: synchronous, active-high reset.
- IRQ  in  15: request lines; bit i-1 is level i; asynchronous to CLK.
- PORT_WR  in  1: port write strobe from core.
- PORT_RD  in  1: port read strobe from core.
- ADRS  in  18: port address from core.
- WDATA  in  18: write data, from core DATAOUT.
- RDATA  out  18: read data to core DATAIN; zero when not selected.
- VECTOR  out  4: highest pending enabled level, 0 = none; to core VECTOR.

Behaviour:
- Reset is synchronous and active-high on CLK. On reset:
  - ENABLE, EDGE, SOFT, PENDING and all synchronizer/edge flops = 0.
  - VECTOR = 0.
  - RDATA = 0 unless a read is in progress.
- Register map, by offset from BASE_ADRS. Only bits [15:1] are used; bits 17:16 and 0 read 0 and ignore writes.
  - Offset 0, ENABLE (R/W): 1 = level unmasked.
  - Offset 1, PENDING. Read returns the raw pending bits (not masked). Write is write-1-to-clear of the edge/soft latches.
  - Offset 2, EDGE (R/W): 1 = rising-edge triggered, 0 = level sensitive.
  - Offset 3, SOFT. Write-1-to-set of the software pending latch. Reads 0.
- Writes take effect at the CLK edge where PORT_WR=1 and ADRS matches.
- RDATA is combinational: the selected register when PORT_RD=1 and ADRS is in range, else 0.
- Synchronizer: IRQ passes through SYNC_STAGES flops, giving sync. One more flop gives prev. rise = sync & ~prev.
- Edge-mode bit, at each edge:
  - latch <= (latch & ~clr) | rise | softset.
  - Set wins over a simultaneous clear.
- Level-mode bit:
  - latch holds soft requests only.
  - PENDING = sync | latch, so it follows the synchronized line while high.
  - W1C clears only the latch; it has no effect while IRQ is held high.
- PENDING is registered. IRQ sampled high at edge N sets PENDING at edge N+SYNC_STAGES (N+2 by default).
- VECTOR is registered from the priority encode of PENDING & ENABLE and updates one edge after PENDING (N+3 by default).
  - Highest set index wins.
  - All zero gives 0.
  - Toggling ENABLE changes VECTOR at the next edge.
- No acknowledge from the core:
  - The ISR must clear the PENDING bit. Until then VECTOR holds the level.
  - While the core runs at that level, the core ignores the equal vector.
  - After RTI restores a lower level, an uncleared request re-interrupts. This is intended.
- A clear of the highest pending bit drops VECTOR to the next-highest pending enabled level at the following edge.
- Switching EDGE on a bit with the line high does not create a rise event, because prev is already high.
- Reset asserted mid-operation overrides all writes in that cycle.

Decomposition:
- Package int_ctrl18_pkg:
  - offset constants OFS_ENABLE=0, OFS_PENDING=1, OFS_EDGE=2, OFS_SOFT=3;
  - NUM_LEVELS=15;
  - the 4-bit vector type.
- One sub-module, irq_sync: a per-bit SYNC_STAGES synchronizer plus rise detector, instantiated as 15 bits wide.
- The priority encoder stays inline.

Test Plan:
1. Reset, then read all four offsets -> RDATA=0 each; VECTOR=0.
2. Write ENABLE=18'o000200 (level 7) and EDGE=18'o000200. Pulse IRQ[6] high one clock at edge N:
   - PENDING reads 18'o000200 from edge N+2;
   - VECTOR=7 at edge N+3 and holds after IRQ falls;
   - write 18'o000200 to PENDING -> VECTOR=0 next edge.
3. Set ENABLE=18'o177776 with IRQ[4] (level 5) and IRQ[11] (level 12) held high, level mode:
   - VECTOR=12;
   - drop IRQ[11] -> VECTOR=5 three edges later;
   - W1C level 5 with the line still high -> VECTOR stays 5.
4. Write SOFT=18'o100000 with ENABLE bit 15 clear -> PENDING=18'o100000 and VECTOR=0. Then set ENABLE bit 15 -> VECTOR=15 next edge.
5. Edge mode, level 3: rise and a W1C of bit 3 in the same cycle -> bit remains set (set wins).
6. With VECTOR=9 pending, assert RESET for one edge mid-write -> all registers 0, VECTOR=0, write discarded.
